// File: rtl/ac97_pkg.sv
// Shared AC'97 frame geometry: slot boundaries, tag bit positions and the
// command record carried from the host side into an outgoing frame.
package ac97_pkg;

    localparam int FRAME_LEN = 256;
    localparam int SLOT_W    = 20;

    localparam logic [7:0] LAST_BIT    = 8'(FRAME_LEN - 1);
    localparam logic [7:0] SLOT1_START = 8'd16;
    localparam logic [7:0] SLOT2_START = 8'd36;
    localparam logic [7:0] SLOT3_START = 8'd56;
    localparam logic [7:0] SLOT4_START = 8'd76;
    localparam logic [7:0] SLOT_END    = 8'd96;

    localparam logic [7:0] TAG_VALID_BIT = 8'd0;
    localparam logic [7:0] TAG_SLOT1_BIT = 8'd1;
    localparam logic [7:0] TAG_SLOT2_BIT = 8'd2;
    localparam logic [7:0] TAG_SLOT3_BIT = 8'd3;
    localparam logic [7:0] TAG_SLOT4_BIT = 8'd4;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef struct packed {
        logic        read;
        logic [6:0]  addr;
        logic [15:0] data;
    } cmd_t;

    // Bit of a 20-bit slot word at frame position b, MSB first from start.
    function automatic logic slot_bit(input slot_t word, input logic [7:0] b,
                                      input logic [7:0] start);
        logic [4:0] offs;
        offs = 5'(b - start);
        return word[5'(SLOT_W - 1) - offs];
    endfunction

endpackage

// File: rtl/ac97_rx_slots.sv
// Deserialises the codec's SDATA_IN stream: tag valid/slot bits and the
// slot 3/4 PCM samples, publishing them once per frame at SLOT_END.
module ac97_rx_slots
    import ac97_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       active_i,
    input  logic [7:0] bit_count_i,
    input  logic       sdata_i,
    output slot_t      left_o,
    output slot_t      right_o,
    output logic       ready_o,
    output logic       codec_ready_o
);

    logic  tag_valid_q, tag_valid_d;
    logic  tag_left_q, tag_left_d;
    logic  tag_right_q, tag_right_d;
    logic  codec_ready_q, codec_ready_d;
    logic  ready_q, ready_d;
    slot_t left_sr_q, left_sr_d;
    slot_t right_sr_q, right_sr_d;
    slot_t left_q, left_d;
    slot_t right_q, right_d;

    always_comb begin
        tag_valid_d   = tag_valid_q;
        tag_left_d    = tag_left_q;
        tag_right_d   = tag_right_q;
        codec_ready_d = codec_ready_q;
        ready_d       = 1'b0;
        left_sr_d     = left_sr_q;
        right_sr_d    = right_sr_q;
        left_d        = left_q;
        right_d       = right_q;
        if (active_i) begin
            if (bit_count_i == TAG_VALID_BIT) tag_valid_d = sdata_i;
            if (bit_count_i == TAG_SLOT3_BIT) tag_left_d  = sdata_i;
            if (bit_count_i == TAG_SLOT4_BIT) tag_right_d = sdata_i;
            if (bit_count_i >= SLOT3_START && bit_count_i < SLOT4_START)
                left_sr_d = {left_sr_q[SLOT_W-2:0], sdata_i};
            if (bit_count_i >= SLOT4_START && bit_count_i < SLOT_END)
                right_sr_d = {right_sr_q[SLOT_W-2:0], sdata_i};
            if (bit_count_i == SLOT1_START) codec_ready_d = tag_valid_q;
            // The strobe fires every frame; only tagged-valid slots replace samples.
            if (bit_count_i == SLOT_END) begin
                ready_d = 1'b1;
                if (tag_valid_q && tag_left_q)  left_d  = left_sr_q;
                if (tag_valid_q && tag_right_q) right_d = right_sr_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tag_valid_q   <= 1'b0;
            tag_left_q    <= 1'b0;
            tag_right_q   <= 1'b0;
            codec_ready_q <= 1'b0;
            ready_q       <= 1'b0;
            left_sr_q     <= '0;
            right_sr_q    <= '0;
            left_q        <= '0;
            right_q       <= '0;
        end else begin
            tag_valid_q   <= tag_valid_d;
            tag_left_q    <= tag_left_d;
            tag_right_q   <= tag_right_d;
            codec_ready_q <= codec_ready_d;
            ready_q       <= ready_d;
            left_sr_q     <= left_sr_d;
            right_sr_q    <= right_sr_d;
            left_q        <= left_d;
            right_q       <= right_d;
        end
    end

    assign left_o        = left_q;
    assign right_o       = right_q;
    assign ready_o       = ready_q;
    assign codec_ready_o = codec_ready_q;

endmodule

// File: rtl/ac97_link.sv
// AC'97 controller link: frame counter, SYNC/SDATA_OUT serialiser with
// PCM shadow registers, codec register command slot, and the receive path.
module ac97_link
    import ac97_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] left_data,
    input  logic [19:0] right_data,
    input  logic        cmd_valid,
    input  logic        cmd_read,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    output logic        sync,
    output logic        sdata_out,
    input  logic        sdata_in,
    output logic [19:0] left_in,
    output logic [19:0] right_in,
    output logic        ready,
    output logic        codec_ready
);

    logic       started_q;
    logic [7:0] bit_count_q, bit_count_d;
    logic       sync_q, sync_d;
    logic       sdata_q, sdata_d;
    logic       held_q, held_d;
    cmd_t       hold_q, hold_d;
    logic       tx_pend_q, tx_pend_d;
    cmd_t       tx_cmd_q, tx_cmd_d;
    slot_t      left_sh_q, left_sh_d;
    slot_t      right_sh_q, right_sh_d;
    logic       frame_end;
    logic       cmd_accept;
    cmd_t       incoming;
    slot_t      slot1_w, slot2_w;

    // cmd handshake: a command transfers on any rising edge where cmd_valid
    // and cmd_ready are both high; cmd_ready stays low while one is held.
    assign cmd_ready = started_q && !held_q;

    always_comb begin
        bit_count_d    = started_q ? bit_count_q + 8'd1 : 8'd0;
        frame_end      = started_q && (bit_count_q == LAST_BIT);
        cmd_accept     = cmd_valid && cmd_ready;
        incoming.read  = cmd_read;
        incoming.addr  = cmd_addr;
        incoming.data  = cmd_data;
        held_d         = held_q;
        hold_d         = hold_q;
        tx_pend_d      = tx_pend_q;
        tx_cmd_d       = tx_cmd_q;
        left_sh_d      = left_sh_q;
        right_sh_d     = right_sh_q;
        if (cmd_accept) begin
            held_d = 1'b1;
            hold_d = incoming;
        end
        if (frame_end) begin
            tx_pend_d  = held_q || cmd_accept;
            tx_cmd_d   = held_q ? hold_q : incoming;
            held_d     = 1'b0;
            left_sh_d  = left_data;
            right_sh_d = right_data;
        end
    end

    // Outputs are registered from the next bit position so they line up with bit_count.
    always_comb begin
        slot1_w = '0;
        slot2_w = '0;
        if (tx_pend_d) begin
            slot1_w = {tx_cmd_d.read, tx_cmd_d.addr, 12'b0};
            if (!tx_cmd_d.read) slot2_w = {tx_cmd_d.data, 4'b0};
        end
        sync_d  = (bit_count_d < SLOT1_START);
        sdata_d = 1'b0;
        if (bit_count_d < SLOT1_START) begin
            if (bit_count_d == TAG_VALID_BIT || bit_count_d == TAG_SLOT3_BIT ||
                bit_count_d == TAG_SLOT4_BIT)
                sdata_d = 1'b1;
            else if (bit_count_d == TAG_SLOT1_BIT || bit_count_d == TAG_SLOT2_BIT)
                sdata_d = tx_pend_d;
        end else if (bit_count_d < SLOT2_START) begin
            sdata_d = slot_bit(slot1_w, bit_count_d, SLOT1_START);
        end else if (bit_count_d < SLOT3_START) begin
            sdata_d = slot_bit(slot2_w, bit_count_d, SLOT2_START);
        end else if (bit_count_d < SLOT4_START) begin
            sdata_d = slot_bit(left_sh_d, bit_count_d, SLOT3_START);
        end else if (bit_count_d < SLOT_END) begin
            sdata_d = slot_bit(right_sh_d, bit_count_d, SLOT4_START);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            started_q   <= 1'b0;
            bit_count_q <= '0;
            sync_q      <= 1'b0;
            sdata_q     <= 1'b0;
            held_q      <= 1'b0;
            hold_q      <= '0;
            tx_pend_q   <= 1'b0;
            tx_cmd_q    <= '0;
            left_sh_q   <= '0;
            right_sh_q  <= '0;
        end else begin
            started_q   <= 1'b1;
            bit_count_q <= bit_count_d;
            sync_q      <= sync_d;
            sdata_q     <= sdata_d;
            held_q      <= held_d;
            hold_q      <= hold_d;
            tx_pend_q   <= tx_pend_d;
            tx_cmd_q    <= tx_cmd_d;
            left_sh_q   <= left_sh_d;
            right_sh_q  <= right_sh_d;
        end
    end

    assign sync      = sync_q;
    assign sdata_out = sdata_q;

    ac97_rx_slots u_rx (
        .clk_i         (clock),
        .reset_i       (reset),
        .active_i      (started_q),
        .bit_count_i   (bit_count_q),
        .sdata_i       (sdata_in),
        .left_o        (left_in),
        .right_o       (right_in),
        .ready_o       (ready),
        .codec_ready_o (codec_ready)
    );

endmodule

// File: tb/tb_ac97_link.sv
// Self-checking bench for ac97_link: directed frames plus randomized frames,
// compared against whole-frame bit vectors built from the slot layout.
module tb_ac97_link;

    logic        clock;
    logic        reset;
    logic [19:0] left_data, right_data;
    logic        cmd_valid, cmd_read;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_ready, sync, sdata_out, sdata_in;
    logic [19:0] left_in, right_in;
    logic        ready, codec_ready;

    int n_assert = 0;
    int n_fail   = 0;

    logic [255:0] exp_q[$];
    logic         m_held;
    logic         m_rd;
    logic [6:0]   m_ad;
    logic [15:0]  m_da;
    logic [19:0]  exp_left, exp_right;
    logic         exp_cr;

    logic [255:0] txv;
    int sync_err, rdy_cnt, rdy_pos, crdy_err, crdy_low;

    ac97_link dut (
        .clock       (clock),
        .reset       (reset),
        .left_data   (left_data),
        .right_data  (right_data),
        .cmd_valid   (cmd_valid),
        .cmd_read    (cmd_read),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .sync        (sync),
        .sdata_out   (sdata_out),
        .sdata_in    (sdata_in),
        .left_in     (left_in),
        .right_in    (right_in),
        .ready       (ready),
        .codec_ready (codec_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Frame as a 256-bit vector, frame bit b at index 255-b.
    function automatic logic [255:0] build_frame(input logic pend, input logic rd,
            input logic [6:0] ad, input logic [15:0] da, input logic [19:0] l,
            input logic [19:0] r);
        logic [15:0] tag;
        logic [19:0] s1, s2;
        tag = {1'b1, pend, pend, 2'b11, 11'b0};
        s1  = pend ? {rd, ad, 12'b0} : 20'b0;
        s2  = (pend && !rd) ? {da, 4'b0} : 20'b0;
        return {tag, s1, s2, l, r, 160'b0};
    endfunction

    function automatic logic [255:0] build_codec(input logic t0, input logic t3,
            input logic t4, input logic [19:0] s3, input logic [19:0] s4);
        return {t0, 2'b00, t3, t4, 11'b0, 40'b0, s3, s4, 160'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one frame starting at the negedge of bit 0; ends at bit 0 of the next.
    task automatic run_frame(input logic [255:0] cv, input int cmd_at, input logic c_rd,
            input logic [6:0] c_ad, input logic [15:0] c_da, input int change_at);
        logic acc, pend, rd;
        logic [6:0]  ad;
        logic [15:0] da;
        sync_err = 0; rdy_cnt = 0; rdy_pos = -1; crdy_err = 0; crdy_low = 0; txv = '0;
        for (int i = 0; i < 256; i++) begin
            sdata_in = cv[255 - i];
            if (i == change_at) begin
                left_data  = 20'($urandom);
                right_data = 20'($urandom);
            end
            cmd_valid = (i == cmd_at);
            cmd_read  = c_rd;
            cmd_addr  = c_ad;
            cmd_data  = c_da;
            txv[255 - i] = sdata_out;
            if (sync !== (i < 16)) sync_err++;
            if (cmd_ready !== !m_held) crdy_err++;
            if (cmd_ready === 1'b0) crdy_low++;
            if (ready === 1'b1) begin
                rdy_cnt++;
                rdy_pos = i;
            end
            acc = cmd_valid && !m_held;
            if (i == 255) begin
                pend = m_held || acc;
                rd   = m_held ? m_rd : c_rd;
                ad   = m_held ? m_ad : c_ad;
                da   = m_held ? m_da : c_da;
                exp_q.push_back(build_frame(pend, rd, ad, da, left_data, right_data));
                m_held = 1'b0;
            end else if (acc) begin
                m_held = 1'b1;
                m_rd = c_rd;
                m_ad = c_ad;
                m_da = c_da;
            end
            @(negedge clock);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [255:0] cv);
        logic [255:0] e;
        e = exp_q.pop_front();
        chk_frame({name, "_tx"}, txv, e);
        chk({name, "_sync_err"}, 32'(sync_err), 32'd0);
        chk({name, "_ready_cnt"}, 32'(rdy_cnt), 32'd1);
        chk({name, "_ready_pos"}, 32'(rdy_pos), 32'd97);
        chk({name, "_cmd_ready"}, 32'(crdy_err), 32'd0);
        if (cv[255] && cv[252]) exp_left  = cv[199:180];
        if (cv[255] && cv[251]) exp_right = cv[179:160];
        exp_cr = cv[255];
        chk({name, "_left_in"}, 32'(left_in), 32'(exp_left));
        chk({name, "_right_in"}, 32'(right_in), 32'(exp_right));
        chk({name, "_codec_ready"}, 32'(codec_ready), 32'(exp_cr));
    endtask

    task automatic release_reset();
        reset = 1'b0;
        m_held = 1'b0;
        exp_left = '0;
        exp_right = '0;
        exp_cr = 1'b0;
        exp_q.delete();
        exp_q.push_back(build_frame(1'b0, 1'b0, 7'h0, 16'h0, 20'h0, 20'h0));
        @(negedge clock);
        chk("rel_sync", 32'(sync), 32'd1);
        chk("rel_sdata_b0", 32'(sdata_out), 32'd1);
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_sync"}, 32'(sync), 32'd0);
        chk({name, "_sdata"}, 32'(sdata_out), 32'd0);
        chk({name, "_ready"}, 32'(ready), 32'd0);
        chk({name, "_codec_ready"}, 32'(codec_ready), 32'd0);
        chk({name, "_left_in"}, 32'(left_in), 32'd0);
        chk({name, "_right_in"}, 32'(right_in), 32'd0);
        chk({name, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    endtask

    initial begin
        logic [255:0] cv;
        int cmd_at;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_data = '0;
        sdata_in = 1'b0; left_data = '0; right_data = '0;
        m_held = 1'b0; m_rd = 1'b0; m_ad = '0; m_da = '0;
        exp_left = '0; exp_right = '0; exp_cr = 1'b0;

        repeat (3) @(negedge clock);
        chk_reset_outputs("por");

        left_data  = 20'hABCDE;
        right_data = 20'h12345;
        release_reset();

        // Frame 0: idle link, codec delivers valid left/right samples.
        cv = build_codec(1'b1, 1'b1, 1'b1, 20'h55555, 20'hAAAAA);
        run_frame(cv, -1, 1'b0, 7'h0, 16'h0, -1);
        check_frame("f0", cv);
        chk("f0_tag", 32'(txv[255:240]), 32'h9800);
        chk("f0_left_in", 32'(left_in), 32'h55555);
        chk("f0_right_in", 32'(right_in), 32'hAAAAA);
        chk("f0_codec_ready", 32'(codec_ready), 32'd1);

        // Frame 1: shadows carry ABCDE/12345 despite a change in slot 3; write at bit 100.
        cv = build_codec(1'b1, 1'b0, 1'b1, 20'h0F0F0, 20'h3C3C3);
        run_frame(cv, 100, 1'b0, 7'h02, 16'h8000, 60);
        check_frame("f1", cv);
        chk("f1_slot3", 32'(txv[199:180]), 32'hABCDE);
        chk("f1_slot4", 32'(txv[179:160]), 32'h12345);
        chk("f1_cmd_ready_low", 32'(crdy_low), 32'd155);
        chk("f1_left_hold", 32'(left_in), 32'h55555);
        chk("f1_right_new", 32'(right_in), 32'h3C3C3);

        // Frame 2: carries the write; read accepted in the very last bit.
        cv = build_codec(1'b0, 1'b1, 1'b1, 20'h11111, 20'h22222);
        run_frame(cv, 255, 1'b1, 7'h7F, 16'hFFFF, -1);
        check_frame("f2", cv);
        chk("f2_tag", 32'(txv[255:240]), 32'hF800);
        chk("f2_slot1", 32'(txv[239:220]), 32'h02000);
        chk("f2_slot2", 32'(txv[219:200]), 32'h80000);
        chk("f2_cmd_ready_low", 32'(crdy_low), 32'd0);
        chk("f2_codec_ready", 32'(codec_ready), 32'd0);

        // Frame 3: the last-bit read goes out with an empty slot 2.
        cv = build_codec(1'b1, 1'b1, 1'b0, 20'($urandom), 20'($urandom));
        run_frame(cv, -1, 1'b0, 7'h0, 16'h0, 10);
        check_frame("f3", cv);
        chk("f3_tag", 32'(txv[255:240]), 32'hF800);
        chk("f3_slot1", 32'(txv[239:220]), 32'hFF000);
        chk("f3_slot2", 32'(txv[219:200]), 32'h00000);

        for (int f = 0; f < 6; f++) begin
            cv = build_codec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), 20'($urandom), 20'($urandom));
            cmd_at = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 255));
            run_frame(cv, cmd_at, 1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom),
                      int'($urandom_range(0, 255)));
            check_frame($sformatf("rnd%0d", f), cv);
        end

        // Reset mid-frame at bit 60 for three cycles.
        for (int i = 0; i < 60; i++) begin
            sdata_in = 1'($urandom);
            @(negedge clock);
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk_reset_outputs("midrst");
        release_reset();
        cv = build_codec(1'b1, 1'b1, 1'b1, 20'($urandom), 20'($urandom));
        run_frame(cv, -1, 1'b0, 7'h0, 16'h0, -1);
        check_frame("post_rst", cv);
        chk("post_rst_slot3", 32'(txv[199:180]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
